// File: rtl/adc128s_pkg.sv
// adc128s_pkg: channel type and frame constants shared by the ADC128S slave model.
package adc128s_pkg;
    typedef logic [2:0] adc_chnl_t;
    localparam adc_chnl_t CH_LD_LFT  = 3'd0;
    localparam adc_chnl_t CH_LD_RGHT = 3'd4;
    localparam adc_chnl_t CH_STEER   = 3'd5;
    localparam adc_chnl_t CH_BATT    = 3'd6;
    localparam int        FRAME_BITS = 16;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with a one-cycle change pulse on the synced level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic chg
);
    logic [STAGES:0] sr;
    assign q   = sr[STAGES-1];
    assign chg = sr[STAGES] ^ sr[STAGES-1];
    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= {(STAGES+1){RST_VAL}};
        else     sr <= {sr[STAGES-1:0], d};
endmodule

// File: rtl/adc128s_fc_slave.sv
// adc128s_fc_slave: SPI slave model of the ADC128S, result of frame N-1's channel sent in frame N.
// Optional frame counter port txn_cnt when ADC_TXN_COUNT_EN is defined.
module adc128s_fc_slave
    import adc128s_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] UNUSED_VAL  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
`ifdef ADC_TXN_COUNT_EN
    ,
    output logic [15:0] txn_cnt
`endif
);
    logic ss_q, ss_chg, sclk_q, sclk_chg;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [15:0] tx_shft;
    logic [13:0] rx_shft;
    logic [4:0]  bit_cnt;
    adc_chnl_t   chnl, new_chnl;
    logic [11:0] result, new_val;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(SS_n), .q(ss_q), .chg(ss_chg));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK), .q(sclk_q), .chg(sclk_chg));

    always_ff @(posedge clk or posedge rst)
        if (rst) mosi_sr <= '0;
        else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};

    assign new_chnl = rx_shft[13:11];
    always_comb
        new_val = (new_chnl == CH_LD_LFT)  ? ld_cell_lft  :
                  (new_chnl == CH_LD_RGHT) ? ld_cell_rght :
                  (new_chnl == CH_STEER)   ? steerPot     :
                  (new_chnl == CH_BATT)    ? batt         : UNUSED_VAL;

    // SS_n edges take priority; SCLK edges only count inside a selected frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chnl    <= '0;
            result  <= '0;
            tx_shft <= '0;
            rx_shft <= '0;
            bit_cnt <= '0;
`ifdef ADC_TXN_COUNT_EN
            txn_cnt <= '0;
`endif
        end else if (ss_chg && !ss_q) begin
            tx_shft <= {4'h0, result};
            rx_shft <= '0;
            bit_cnt <= '0;
        end else if (ss_chg && ss_q) begin
            if (bit_cnt == 5'(FRAME_BITS)) begin
                chnl   <= new_chnl;
                result <= new_val;
`ifdef ADC_TXN_COUNT_EN
                txn_cnt <= txn_cnt + 16'd1;
`endif
            end
        end else if (!ss_q && sclk_chg) begin
            if (sclk_q) begin
                rx_shft <= {rx_shft[12:0], mosi_sr[SYNC_STAGES-1]};
                bit_cnt <= (bit_cnt == 5'(FRAME_BITS)) ? bit_cnt : bit_cnt + 5'd1;
            end else if (bit_cnt != 5'd0) begin
                tx_shft <= {tx_shft[14:0], 1'b0};
            end
        end
    end

    assign MISO = tx_shft[15] & ~ss_q;
endmodule

// File: tb/tb_adc128s_fc_slave.sv
// tb_adc128s_fc_slave: SPI master (SCLK = clk/32) against a frame-level model of the ADC.
module tb_adc128s_fc_slave;
    logic clk = 1'b0, rst = 1'b1, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
    logic MISO;
    logic [11:0] ld_cell_lft = '0, ld_cell_rght = '0, steerPot = '0, batt = '0;
    int vecs = 0, errs = 0, n_txn = 0;
    logic [15:0] exp_nxt = '0, got;
`ifdef ADC_TXN_COUNT_EN
    logic [15:0] txn_cnt;
`endif

    adc128s_fc_slave dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght),
        .steerPot(steerPot), .batt(batt)
`ifdef ADC_TXN_COUNT_EN
        , .txn_cnt(txn_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_val(logic [2:0] c);
        logic [11:0] tbl [8];
        tbl = '{default: 12'h000};
        tbl[0] = ld_cell_lft;
        tbl[4] = ld_cell_rght;
        tbl[5] = steerPot;
        tbl[6] = batt;
        return tbl[c];
    endfunction

    task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
        vecs++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic xfer(logic [15:0] cmd, int nbits, bit close, output logic [15:0] r);
        r = '0;
        SS_n = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            repeat (16) @(negedge clk);
            r[15-i] = MISO;
            SCLK = 1'b1;
            repeat (16) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (16) @(negedge clk);
        if (close) begin
            SS_n = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic frame(string tag, logic [2:0] c, int nbits = 16);
        logic [15:0] cmd, mask;
        cmd = 16'($urandom);
        cmd[13:11] = c;
        xfer(cmd, nbits, 1'b1, got);
        mask = 16'hFFFF << (16 - nbits);
        chk(tag, got & mask, exp_nxt & mask);
        if (nbits == 16) begin
            exp_nxt = {4'h0, ref_val(c)};
            n_txn++;
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #1;
        chk("rst_miso", {15'h0, MISO}, 16'h0000);
        repeat (2) @(negedge clk);
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        rst = 1'b0;
        exp_nxt = '0;
        n_txn = 0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_miso", {15'h0, MISO}, 16'h0000);
`ifdef ADC_TXN_COUNT_EN
        chk("reset_txn", txn_cnt, 16'h0000);
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ld_cell_lft = 12'd330;
        frame("first_after_rst", 3'd0);
        ld_cell_rght = 12'd330;
        steerPot = 12'h800;
        frame("ch0_readback", 3'd4);
        frame("ch4_readback", 3'd5);
        batt = 12'hFFF;
        frame("ch5_readback", 3'd6);
        fork
            frame("ch6_latched", 3'd2);
            begin
                repeat (200) @(negedge clk);
                batt = 12'h000;
            end
        join
        frame("ch2_unused", 3'd5);
        frame("abort_partial", 3'd0, 8);
        frame("after_abort", 3'd0);
        batt = 12'hFFF;
        frame("pre_rst_set", 3'd6);
        xfer(16'h0000, 6, 1'b0, got);
        chk("pre_rst_miso", {15'h0, MISO}, {15'h0, exp_nxt[9]});
        @(negedge clk);
        do_rst();
        frame("post_rst", 3'd0);
        for (int k = 0; k < 24; k++) begin
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            steerPot     = 12'($urandom);
            batt         = 12'($urandom);
            frame("rand", 3'($urandom_range(7)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 16);
        end
`ifdef ADC_TXN_COUNT_EN
        chk("txn_rand", txn_cnt, 16'(n_txn));
        do_rst();
        frame("txn_f1", 3'd0);
        frame("txn_f2", 3'd4);
        frame("txn_f3", 3'd5);
        frame("txn_abort", 3'd6, 5);
        chk("txn_three", txn_cnt, 16'd3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
